// File: rtl/demux_1_8_stream_if.sv
// Stream bundle for the 1-to-8 demultiplexer.
// One producer port fanned out to eight valid/ready consumer channels.
interface demux_1_8_stream_if #(
    parameter int WIDTH = 32
);
    logic [2:0]         select;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic [7:0]         out_valid;
    logic [8*WIDTH-1:0] out_data;
    logic [7:0]         out_ready;
    logic [3:0]         occupancy;

    modport master (
        output select, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  select, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/demux_1_8_stream.sv
// Registered 1-to-8 stream demux with a one-word buffer per channel.
// A full, stalled channel only blocks words addressed to it.
module demux_1_8_stream #(
    parameter int WIDTH = 32
) (
    input logic                 clock,
    input logic                 reset_n,
    demux_1_8_stream_if.slave   bus
);
    logic [7:0]         full_q, full_d;
    logic [8*WIDTH-1:0] data_q, data_d;
    logic [3:0]         occ_q, occ_d;
    logic               acc;

    assign bus.in_ready  = ~full_q[bus.select] | bus.out_ready[bus.select];
    assign acc           = bus.in_valid & bus.in_ready;
    assign bus.out_valid = full_q;
    assign bus.out_data  = data_q;
    assign bus.occupancy = occ_q;

    always_comb begin
        // Drains clear first; an accept to the same channel re-sets it.
        full_d = full_q & ~bus.out_ready;
        data_d = data_q;
        for (int k = 0; k < 8; k++) begin
            if (acc && bus.select == 3'(k)) begin
                full_d[k] = 1'b1;
                data_d[k*WIDTH +: WIDTH] = bus.in_data;
            end
        end
        occ_d = 4'd0;
        for (int k = 0; k < 8; k++) begin
            occ_d = occ_d + {3'b000, full_d[k]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            full_q <= 8'h00;
            data_q <= '0;
            occ_q  <= 4'd0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            occ_q  <= occ_d;
        end
    end
endmodule

// File: tb/tb_demux_1_8_stream.sv
// Directed bench for demux_1_8_stream.
// Linear steps with immediate-assertion checks.
module tb_demux_1_8_stream;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    demux_1_8_stream_if #(.WIDTH(32)) bus ();

    demux_1_8_stream #(.WIDTH(32)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slice(input int k);
        return bus.out_data[k*32 +: 32];
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b1;
        bus.select    = 3'd0;
        bus.in_data   = 32'hDEAD_BEEF;
        bus.out_ready = 8'h00;

        // Reset with in_valid held high
        tick();
        tick();
        chk("rst_out_valid", 256'(bus.out_valid), 256'h00);
        chk("rst_occ", 256'(bus.occupancy), 256'd0);
        chk("rst_out_data", 256'(bus.out_data), 256'd0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 256'(bus.in_ready), 256'd1);

        // Fan-out to all eight channels
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.select   = 3'(k);
            bus.in_data  = 32'h1000_0000 + 32'(k);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("fan_out_valid", 256'(bus.out_valid), 256'hFF);
        chk("fan_occ", 256'(bus.occupancy), 256'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fan_slice%0d", k), 256'(slice(k)),
                256'(32'h1000_0000 + 32'(k)));
        end
        bus.in_valid = 1'b1;
        bus.select   = 3'd3;
        bus.in_data  = 32'h9999_9999;
        #1;
        chk("fan_full_in_ready", 256'(bus.in_ready), 256'd0);
        bus.in_valid = 1'b0;
        bus.out_ready = 8'hFF;
        tick();
        bus.out_ready = 8'h00;
        chk("drain_all_valid", 256'(bus.out_valid), 256'h00);
        chk("drain_all_occ", 256'(bus.occupancy), 256'd0);

        // Streaming through channel 5
        bus.out_ready = 8'h20;
        bus.select    = 3'd5;
        bus.in_valid  = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            bus.in_data = 32'(w);
            #1;
            chk($sformatf("stream_in_ready%0d", w), 256'(bus.in_ready), 256'd1);
            tick();
            chk($sformatf("stream_slice%0d", w), 256'(slice(5)), 256'(w));
            chk($sformatf("stream_valid%0d", w), 256'(bus.out_valid), 256'h20);
            chk($sformatf("stream_occ%0d", w), 256'(bus.occupancy), 256'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 8'h00;
        chk("stream_end_occ", 256'(bus.occupancy), 256'd0);

        // Head-of-line isolation on channel 2
        bus.in_valid = 1'b1;
        bus.select   = 3'd2;
        bus.in_data  = 32'h0000_0022;
        tick();
        bus.in_data  = 32'h0000_0099;
        #1;
        chk("hol_in_ready2", 256'(bus.in_ready), 256'd0);
        tick();
        chk("hol_keep_old", 256'(slice(2)), 256'h22);
        chk("hol_occ1", 256'(bus.occupancy), 256'd1);
        bus.select  = 3'd6;
        bus.in_data = 32'h0000_0066;
        #1;
        chk("hol_in_ready6", 256'(bus.in_ready), 256'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("hol_valid", 256'(bus.out_valid), 256'h44);
        chk("hol_occ2", 256'(bus.occupancy), 256'd2);
        chk("hol_slice6", 256'(slice(6)), 256'h66);
        bus.out_ready = 8'hFF;
        tick();
        bus.out_ready = 8'h00;

        // Simultaneous drain+accept on ch4, drain on ch1
        bus.in_valid = 1'b1;
        bus.select   = 3'd4;
        bus.in_data  = 32'h0000_AAAA;
        tick();
        bus.select   = 3'd1;
        bus.in_data  = 32'h0000_0011;
        tick();
        chk("sim_pre_occ", 256'(bus.occupancy), 256'd2);
        bus.select    = 3'd4;
        bus.in_data   = 32'h0000_BBBB;
        bus.out_ready = 8'h12;
        #1;
        chk("sim_in_ready", 256'(bus.in_ready), 256'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h00;
        chk("sim_valid", 256'(bus.out_valid), 256'h10);
        chk("sim_slice4", 256'(slice(4)), 256'hBBBB);
        chk("sim_occ", 256'(bus.occupancy), 256'd1);

        // Reset mid-operation with an accept pending
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.select  = 3'(k);
            bus.in_data = 32'h5000_0000 + 32'(k);
            tick();
        end
        chk("mid_pre_occ", 256'(bus.occupancy), 256'd5);
        bus.select  = 3'd7;
        bus.in_data = 32'h0000_0077;
        rst_n = 1'b0;
        tick();
        chk("mid_valid", 256'(bus.out_valid), 256'h00);
        chk("mid_occ", 256'(bus.occupancy), 256'd0);
        chk("mid_data", 256'(bus.out_data), 256'd0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        chk("mid_after_valid", 256'(bus.out_valid), 256'h00);
        chk("mid_after_ready", 256'(bus.in_ready), 256'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
